// File: rtl/fsm_frame_runner.sv
// Frame sequencer around a 5-state serial pattern FSM (z = state D or E).
// Shifts each accepted frame MSB-first through the FSM and reports hit count and final state.
//
// Handshake contract (both ports):
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - A producer holds its payload stable for as long as valid is high and ready is low.
//   - Input port: ready is high only in IDLE, and in_data is sampled only on the accept edge.
//   - Output port: the result record stays valid and stable until out_ready is seen high.
module fsm_frame_runner #(
    parameter  int W  = 8,
    localparam int HW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [HW-1:0] out_hits,
    output logic          out_z,
    output logic [2:0]    out_state,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} ctrl_t;
    typedef enum logic [2:0] {S_A = 3'd0, S_B = 3'd1, S_C = 3'd2, S_D = 3'd3, S_E = 3'd4} fsm_t;

    ctrl_t         ctrl, ctrl_next;
    fsm_t          fsm, fsm_next;
    logic [W-1:0]  shreg;
    logic [HW-1:0] bitcnt;
    logic [HW-1:0] hits;
    logic          bit_x;
    logic          step_hit;

    assign bit_x = shreg[W-1];

    // Serial pattern FSM transition; unused encodings fall back to A.
    always_comb begin
        fsm_next = S_A;
        case (fsm)
            S_A:     fsm_next = bit_x ? S_B : S_A;
            S_B:     fsm_next = bit_x ? S_E : S_B;
            S_C:     fsm_next = bit_x ? S_B : S_C;
            S_D:     fsm_next = bit_x ? S_C : S_B;
            S_E:     fsm_next = bit_x ? S_E : S_D;
            default: fsm_next = S_A;
        endcase
    end

    assign step_hit = (fsm_next == S_D) || (fsm_next == S_E);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl <= IDLE;
        end else begin
            ctrl <= ctrl_next;
        end
    end

    always_comb begin
        ctrl_next = ctrl;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (ctrl)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) ctrl_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (bitcnt == HW'(1)) ctrl_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) ctrl_next = IDLE;
            end
            default: ctrl_next = IDLE;
        endcase
        // Abort wins over any accept or completion in the same cycle.
        if (flush) ctrl_next = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm    <= S_A;
            shreg  <= '0;
            bitcnt <= '0;
            hits   <= '0;
        end else if (flush) begin
            fsm    <= S_A;
            bitcnt <= '0;
            hits   <= '0;
        end else begin
            case (ctrl)
                IDLE: begin
                    if (in_valid) begin
                        shreg  <= in_data;
                        bitcnt <= HW'(W);
                        hits   <= '0;
                        fsm    <= S_A;
                    end
                end
                RUN: begin
                    fsm    <= fsm_next;
                    shreg  <= {shreg[W-2:0], 1'b0};
                    bitcnt <= bitcnt - HW'(1);
                    if (step_hit) hits <= hits + HW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_hits  = hits;
    assign out_z     = (fsm == S_D) || (fsm == S_E);
    assign out_state = fsm;

endmodule

// File: tb/tb_fsm_frame_runner.sv
// Bench for fsm_frame_runner: directed frames, backpressure, flush, async reset,
// then a random frame stream scored against a table-driven model of the serial FSM.
module tb_fsm_frame_runner;

    localparam int W  = 8;
    localparam int HW = $clog2(W + 1);

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [HW-1:0] out_hits;
    logic          out_z;
    logic [2:0]    out_state;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [HW+3:0] exp_q[$];

    // next state per (state, bit): A=0 B=1 C=2 D=3 E=4
    int tab [5][2] = '{'{0, 1}, '{1, 4}, '{2, 1}, '{1, 2}, '{3, 4}};

    fsm_frame_runner #(.W(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hits  (out_hits),
        .out_z     (out_z),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Record layout: {hits, z, state}
    function automatic logic [HW+3:0] model(input logic [W-1:0] d);
        int st = 0;
        int h  = 0;
        for (int i = W - 1; i >= 0; i--) begin
            st = tab[st][d[i]];
            if (st == 3 || st == 4) h++;
        end
        return {HW'(h), (st >= 3) ? 1'b1 : 1'b0, 3'(st)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one frame from IDLE, wait for its result, hold out_ready low for
    // 'hold' cycles (optionally keeping in_valid high), then complete the handshake.
    task automatic send(input logic [W-1:0] d, input int hold, input bit hold_valid);
        logic [HW+3:0] rec;
        int lat;
        check("in_ready_idle", in_ready, 1);
        exp_q.push_back(model(d));
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        check("busy_after_accept", busy, 1);
        check("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("latency", lat, W);
        check("busy_done", busy, 0);
        rec = exp_q.pop_front();
        check("out_hits", out_hits, rec[HW+3:4]);
        check("out_z", out_z, rec[3]);
        check("out_state", out_state, rec[2:0]);
        if (hold_valid) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_hits", out_hits, rec[HW+3:4]);
            check("hold_state", out_state, rec[2:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("no_accept_on_handshake", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_hits"}, out_hits, 0);
        check({tag, "_out_z"}, out_z, 0);
        check({tag, "_out_state"}, out_state, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit seen_valid;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        resetn = 1'b1;

        // directed frames from the plan
        send(8'hFF, 0, 1'b0);
        send(8'b1100_0000, 0, 1'b0);
        send(8'b1101_0000, 0, 1'b0);
        send(8'h00, 0, 1'b0);

        // backpressure with a new frame waiting on in_valid
        send(8'hA5, 5, 1'b1);
        send(8'h3C, 2, 1'b0);

        // flush at step 4 of an all-ones frame
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_hits", out_hits, 0);
        check("flush_state", out_state, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("flush_no_result", seen_valid, 0);

        // frame offered together with flush must be ignored
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_blocks_accept", busy, 0);
        send(8'h80, 0, 1'b0);

        // asynchronous reset between edges mid-frame
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("pre_reset_hits", out_hits, 2);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        resetn = 1'b1;

        // random stream
        for (int n = 0; n < 200; n++) begin
            send(W'($urandom), $urandom_range(0, 3), 1'b0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
